// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the control-state encoding and the bit-counter sizing function.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  // The counter must be able to hold WIDTH itself, so size for WIDTH+1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out.
// Purely combinational; the serial datapath reuses a single instance for every bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b - bin, LSB first.
// A single full-subtractor slice is stepped across WIDTH bits between two valid/ready handshakes.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  sub_state_t       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             borrow_next;
  logic             d;
  logic             a_msb;
  logic             b_msb;
  logic             accept;
  logic             last_bit;

  full_subtractor u_slice (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d),
    .bout (borrow_next)
  );

  assign accept   = (state == IDLE) && start_valid;
  assign last_bit = (state == RUN) && (cnt == LAST);

  // New bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at the LSB.
  assign res_next = (res_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the always blocks execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = ~reset;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bin;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      borrow <= borrow_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        diff <= res_next;
        bout <= borrow_next;
        // Overflow only when the operands' signs differ and the result sign leaves a's.
        ovf  <= (a_msb ^ b_msb) & (d ^ a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
// Expected results come from an integer arithmetic model of a - b - bin.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       sv8 = 1'b0;
  logic       sr8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       dv8;
  logic       dr8 = 1'b0;
  logic [7:0] diff8;
  logic       bout8;
  logic       ovf8;
  logic       busy8;

  logic       sv4 = 1'b0;
  logic       sr4;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       dv4;
  logic       dr4 = 1'b1;
  logic [3:0] diff4;
  logic       bout4;
  logic       ovf4;
  logic       busy4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .bin(bin8), .done_valid(dv8), .done_ready(dr8),
    .diff(diff8), .bout(bout8), .ovf(ovf8), .busy(busy8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .bin(bin4), .done_valid(dv4), .done_ready(dr4),
    .diff(diff4), .bout(bout4), .ovf(ovf4), .busy(busy4)
  );

  // Returns {ovf, bout, diff[31:0]} for a w-bit subtraction a - b - bin.
  function automatic logic [33:0] model(input int w, input int a, input int b, input int bin);
    int          r;
    int          sa;
    int          sb;
    int          sr;
    logic [31:0] m;
    r  = a - b - bin;
    m  = (32'd1 << w) - 32'd1;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr = sa - sb - bin;
    return {(sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1))), r < 0, 32'(r) & m};
  endfunction

  // Presents an operand set to dut8 and returns #1 after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int guard = 0;
    while (!sr8 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a8 = a; b8 = b; bin8 = bin; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask

  task automatic wait_done8(inout int lat);
    while (!dv8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept8();
    dr8 = 1'b1;
    @(posedge clk); #1;
    dr8 = 1'b0;
  endtask

  task automatic check_result8(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic bin);
    logic [33:0] exp;
    exp = model(8, int'(a), int'(b), int'(bin));
    checks++;
    if (dv8 !== 1'b1 || diff8 !== exp[7:0] || bout8 !== exp[32] || ovf8 !== exp[33]) begin
      errors++;
      $display("FAIL %s: got dv=%b diff=%h bout=%b ovf=%b, expected dv=1 diff=%h bout=%b ovf=%b",
               name, dv8, diff8, bout8, ovf8, exp[7:0], exp[32], exp[33]);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if (diff8 !== 8'h00 || bout8 !== 1'b0 || ovf8 !== 1'b0 || dv8 !== 1'b0 || busy8 !== 1'b0 ||
        sr8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got diff=%h bout=%b ovf=%b dv=%b busy=%b sr=%b, expected all 0",
               diff8, bout8, ovf8, dv8, busy8, sr8);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sr8 !== 1'b1 || sr4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got sr8=%b sr4=%b, expected 1", sr8, sr4);
    end
  endtask

  task automatic test_basic();
    int lat = 0;
    issue8(8'd100, 8'd37, 1'b0);
    wait_done8(lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges, expected 8", lat);
    end
    check_result8("basic_100_minus_37", 8'd100, 8'd37, 1'b0);
    accept8();
    checks++;
    if (dv8 !== 1'b0 || diff8 !== 8'h3F) begin
      errors++;
      $display("FAIL basic_after_accept: got dv=%b diff=%h, expected dv=0 diff=3f", dv8, diff8);
    end
  endtask

  task automatic test_borrow_ovf();
    logic [16:0] tbl [3];
    tbl[0] = {8'h00, 8'h01, 1'b0};
    tbl[1] = {8'h80, 8'h01, 1'b0};
    tbl[2] = {8'h05, 8'h05, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int lat = 0;
      issue8(tbl[i][16:9], tbl[i][8:1], tbl[i][0]);
      wait_done8(lat);
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL edge_case_latency[%0d]: got %0d, expected 8", i, lat);
      end
      check_result8($sformatf("edge_case[%0d]", i), tbl[i][16:9], tbl[i][8:1], tbl[i][0]);
      accept8();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;
      int         lat = 0;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      issue8(ra, rb, rbin);
      wait_done8(lat);
      check_result8($sformatf("random[%0d] %h-%h-%b", i, ra, rb, rbin), ra, rb, rbin);
      accept8();
    end
  endtask

  task automatic test_backpressure();
    int         lat = 0;
    logic [7:0] hd;
    logic       hb;
    logic       ho;
    issue8(8'h80, 8'h01, 1'b0);
    wait_done8(lat);
    hd = diff8; hb = bout8; ho = ovf8;
    check_result8("backpressure_result", 8'h80, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dv8 !== 1'b1 || diff8 !== 8'h7F || bout8 !== 1'b0 || ovf8 !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got dv=%b diff=%h bout=%b ovf=%b, expected 1 7f 0 1 (was %h %b %b)",
                 i, dv8, diff8, bout8, ovf8, hd, hb, ho);
      end
    end
    accept8();
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    issue8(8'h3C, 8'h11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sv8 = 1'b1;
      checks++;
      if (sr8 !== 1'b0) begin
        errors++;
        $display("FAIL ignore_run_ready[%0d]: got start_ready=%b, expected 0", i, sr8);
      end
      @(posedge clk); #1;
      lat++;
    end
    sv8 = 1'b0;
    wait_done8(lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL ignore_latency: got %0d, expected 8", lat);
    end
    a8 = 8'hFF; b8 = 8'h00; sv8 = 1'b1;
    checks++;
    if (sr8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done_ready: got start_ready=%b, expected 0", sr8);
    end
    @(posedge clk); #1;
    sv8 = 1'b0;
    check_result8("ignore_result", 8'h3C, 8'h11, 1'b1);
    accept8();
    lat = 0;
    issue8(8'h12, 8'h34, 1'b0);
    wait_done8(lat);
    check_result8("ignore_following_op", 8'h12, 8'h34, 1'b0);
    accept8();
  endtask

  task automatic test_reset_mid_run();
    int lat = 0;
    issue8(8'h77, 8'h22, 1'b0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (dv8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run_outputs: got dv=%b busy=%b diff=%h bout=%b ovf=%b, expected all 0",
               dv8, busy8, diff8, bout8, ovf8);
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dv8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_run_idle[%0d]: got dv=%b busy=%b, expected 0 0", i, dv8, busy8);
      end
    end
    issue8(8'hA5, 8'h5A, 1'b0);
    wait_done8(lat);
    checks++;
    if (diff8 !== 8'h4B || bout8 !== 1'b0 || ovf8 !== 1'b1 || dv8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run_next: got dv=%b diff=%h bout=%b ovf=%b, expected 1 4b 0 1",
               dv8, diff8, bout8, ovf8);
    end
    accept8();
  endtask

  task automatic test_exhaustive4();
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [33:0] exp;
          int          guard = 0;
          while (!sr4 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
          end
          a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); sv4 = 1'b1;
          @(posedge clk); #1;
          sv4 = 1'b0;
          guard = 0;
          while (!dv4 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
          end
          exp = model(4, ia, ib, ic);
          checks++;
          if (dv4 !== 1'b1 || guard != 4 || diff4 !== exp[3:0] || bout4 !== exp[32] ||
              ovf4 !== exp[33]) begin
            errors++;
            $display("FAIL exhaustive4 %h-%h-%0d: got dv=%b lat=%0d diff=%h bout=%b ovf=%b, expected dv=1 lat=4 diff=%h bout=%b ovf=%b",
                     ia, ib, ic, dv4, guard, diff4, bout4, ovf4, exp[3:0], exp[32], exp[33]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_random();
    test_backpressure();
    test_ignore_start();
    test_reset_mid_run();
    test_exhaustive4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor that computes diff = a - b - bin, one bit per clock, LSB first. A single full-subtractor slice is time-multiplexed across the operand width. Operands are accepted through a valid/ready handshake and the result is returned through a second valid/ready handshake. It is the area-minimal counterpart to the combinational adder datapath, for use where throughput is not critical.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start_valid  input  1  operands a, b and bin are valid this cycle.
start_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow in.
done_valid  output  1  diff, bout and ovf are valid.
done_ready  input  1  consumer accepts the result.
diff  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
bout  output  1  borrow out; 1 when unsigned a < b + bin.
ovf  output  1  signed overflow flag.
busy  output  1  high in RUN and DONE.

Behaviour:
- Reset: one clock; asynchronous, active-high.
  - While reset is asserted, state is IDLE and diff, bout, ovf, done_valid, busy are all 0.
  - start_ready is forced to 0 while reset is asserted and is 1 from the first cycle after reset deasserts.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On a rising edge with start_valid = 1, latch a into shift register A and b into shift register B.
  - Set the borrow flop to bin, clear the bit counter, save a[WIDTH-1] and b[WIDTH-1], then go to RUN.
  - diff, bout and ovf are not cleared on accept; they hold their previous values until the new result lands.
- RUN (exactly WIDTH edges):
  - Each edge computes d = A[0] ^ B[0] ^ borrow and borrow_next = (~A[0] & B[0]) | (~A[0] & borrow) | (B[0] & borrow).
  - Shift d into the result register at the MSB end, shifting it right.
  - Shift A and B right by one bit and increment the counter.
  - On the edge that processes bit WIDTH-1, go to DONE and, on that same edge:
    - load diff from the completed result register;
    - set bout = borrow_next;
    - set ovf = (a_msb ^ b_msb) & (d ^ a_msb).
- DONE:
  - done_valid = 1; diff, bout and ovf are held stable.
  - On a rising edge with done_ready = 1, go to IDLE. done_valid drops after that edge; diff, bout and ovf keep their values.
  - If done_ready is already high on entry, the result is accepted on the first DONE edge, so done_valid is high for one cycle.
- Latency:
  - done_valid rises WIDTH edges after the accepting edge.
  - Minimum issue interval is WIDTH + 2 cycles.
  - There is no overlap: a new start is not accepted in the same cycle as done acceptance.
- Boundaries:
  - start_valid during RUN or DONE is ignored (start_ready = 0). The operands are not captured and the handshake is not acknowledged.
  - a, b and bin changing after acceptance have no effect on the result.
  - For WIDTH = 1, RUN lasts a single edge.
  - Counter width is $clog2(WIDTH+1); it never wraps within an operation.
  - Reset asserted mid-RUN or mid-DONE aborts the operation immediately. The partial result is discarded and no done_valid is produced.
- Arithmetic: diff is modulo 2^WIDTH; bout is the unsigned borrow; ovf is the two's-complement overflow of a - b - bin.

Decomposition:
- Shared package serial_sub_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  - the counter-width function.
- One combinational sub-module, full_subtractor, with inputs (a, b, bin) and outputs (d, bout), instantiated once for the bit slice.
- Control FSM, shift registers and result register stay in serial_subtractor.

Test Plan:
- Reset check: assert reset, then release. Expect diff = 0, bout = 0, ovf = 0, done_valid = 0, busy = 0 during reset, and start_ready = 1 on the cycle after release.
- Basic subtract, WIDTH = 8: a = 8'd100, b = 8'd37, bin = 0. Expect diff = 8'h3F, bout = 0, ovf = 0, with done_valid rising exactly 8 edges after the accepting edge.
- Borrow and overflow cases:
  - 8'h00 - 8'h01 -> diff = 8'hFF, bout = 1, ovf = 0.
  - 8'h80 - 8'h01 -> diff = 8'h7F, bout = 0, ovf = 1.
  - 8'h05 - 8'h05 with bin = 1 -> diff = 8'hFF, bout = 1, ovf = 0.
- Backpressure and ignore rules:
  - Hold done_ready = 0 for 5 cycles in DONE: diff, bout, ovf and done_valid stay stable.
  - Pulse start_valid during RUN and DONE: no capture, and the following op still returns the correct result.
- Reset mid-RUN: assert reset after the 4th RUN edge. done_valid never rises, all outputs go to 0, and a following 8'hA5 - 8'h5A returns diff = 8'h4B, bout = 0, ovf = 1.
- Exhaustive check at WIDTH = 4: all 16 x 16 x 2 (a, b, bin) combinations, issued back-to-back with done_ready = 1. Every result matches the model {bout, diff} = {1'b0, a} - b - bin, and ovf matches the signed model.
